// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: latches cause/EPC/MTVAL, pulses CSR updates, redirects fetch.
// Optional `TRAP_VECTORED_EN enables vectored interrupt targets (mtvec MODE=01).
module trap_ctrl (
  input  logic        ck_i,
  input  logic        rs_n_i,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_ins_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        illegal_ins_i,
  input  logic        ld_misalign_i,
  input  logic        st_misalign_i,
  input  logic        mret_i,
  input  logic [31:0] misalign_addr_i,
  input  logic        mstatus_ie_i,
  input  logic        mie_external_i,
  input  logic        mie_timer_i,
  input  logic        mie_sw_i,
  input  logic        mip_external_i,
  input  logic        mip_timer_i,
  input  logic        mip_software_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] epc_i,
  output logic        kill_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        ie_type_o,
  output logic        set_cause_o,
  output logic [3:0]  trap_cause_o,
  output logic        set_epc_o,
  output logic [31:0] epc_o,
  output logic        set_mtval_o,
  output logic [31:0] mtval_o,
  output logic        mstatus_ie_clear_o,
  output logic        mstatus_ie_set_o
);

  typedef enum logic [1:0] {
    IDLE,
    TRAP_CSR,
    TRAP_JUMP,
    MRET_JUMP
  } state_t;

  state_t state;

  logic        irq_ext;
  logic        irq_sw;
  logic        irq_tmr;
  logic        irq_any;
  logic        exc_any;
  logic        accept;
  logic        trap_d;
  logic        mret_d;
  logic [3:0]  cause_d;
  logic        ie_d;
  logic [31:0] mtval_d;
  logic [31:0] redirect_pc_q;
  logic [31:0] jump_base;
  logic [31:0] jump_pc;
  logic        vec_sel;

  assign irq_ext = mip_external_i & mie_external_i;
  assign irq_sw  = mip_software_i & mie_sw_i;
  assign irq_tmr = mip_timer_i & mie_timer_i;
  assign irq_any = mstatus_ie_i & (irq_ext | irq_sw | irq_tmr);

  assign exc_any = illegal_ins_i | ecall_i | ebreak_i
                 | ld_misalign_i | st_misalign_i;

  assign accept = ex_valid_i & (state == IDLE);
  assign trap_d = accept & (irq_any | exc_any);
  assign mret_d = accept & mret_i & ~trap_d;

  // gated by reset so every output reads 0 while rs_n_i is low
  assign kill_o = rs_n_i & (trap_d | mret_d);

  always_comb begin
    cause_d = 4'd0;
    ie_d    = 1'b0;
    mtval_d = 32'd0;
    if (irq_any) begin
      ie_d = 1'b1;
      if (irq_ext)
        cause_d = 4'd11;
      else if (irq_sw)
        cause_d = 4'd3;
      else
        cause_d = 4'd7;
    end else if (illegal_ins_i) begin
      cause_d = 4'd2;
      mtval_d = ex_ins_i;
    end else if (ecall_i) begin
      cause_d = 4'd11;
    end else if (ebreak_i) begin
      cause_d = 4'd3;
      mtval_d = ex_pc_i;
    end else if (ld_misalign_i) begin
      cause_d = 4'd4;
      mtval_d = misalign_addr_i;
    end else if (st_misalign_i) begin
      cause_d = 4'd6;
      mtval_d = misalign_addr_i;
    end
  end

`ifdef TRAP_VECTORED_EN
  assign vec_sel = (mtvec_i[1:0] == 2'b01) & ie_type_o;
`else
  assign vec_sel = (mtvec_i[1:0] == 2'b01) & 1'b0;
`endif

  assign jump_base = {mtvec_i[31:2], 2'b00};
  assign jump_pc   = jump_base
                   + (vec_sel ? {26'd0, trap_cause_o, 2'b00} : 32'd0);

  // MEPC is read live in MRET_JUMP so a write committed the cycle before lands
  assign redirect_pc_o = (state == MRET_JUMP) ? epc_i : redirect_pc_q;

  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      state              <= IDLE;
      stall_o            <= 1'b0;
      flush_o            <= 1'b0;
      redirect_o         <= 1'b0;
      redirect_pc_q      <= 32'd0;
      ie_type_o          <= 1'b0;
      set_cause_o        <= 1'b0;
      trap_cause_o       <= 4'd0;
      set_epc_o          <= 1'b0;
      epc_o              <= 32'd0;
      set_mtval_o        <= 1'b0;
      mtval_o            <= 32'd0;
      mstatus_ie_clear_o <= 1'b0;
      mstatus_ie_set_o   <= 1'b0;
    end else begin
      stall_o            <= 1'b0;
      flush_o            <= 1'b0;
      redirect_o         <= 1'b0;
      set_cause_o        <= 1'b0;
      set_epc_o          <= 1'b0;
      set_mtval_o        <= 1'b0;
      mstatus_ie_clear_o <= 1'b0;
      mstatus_ie_set_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trap_d) begin
            state              <= TRAP_CSR;
            trap_cause_o       <= cause_d;
            ie_type_o          <= ie_d;
            epc_o              <= ex_pc_i;
            mtval_o            <= mtval_d;
            set_cause_o        <= 1'b1;
            set_epc_o          <= 1'b1;
            set_mtval_o        <= 1'b1;
            mstatus_ie_clear_o <= 1'b1;
            stall_o            <= 1'b1;
            flush_o            <= 1'b1;
          end else if (mret_d) begin
            state            <= MRET_JUMP;
            mstatus_ie_set_o <= 1'b1;
            redirect_o       <= 1'b1;
            flush_o          <= 1'b1;
          end
        end
        TRAP_CSR: begin
          state         <= TRAP_JUMP;
          redirect_o    <= 1'b1;
          flush_o       <= 1'b1;
          redirect_pc_q <= jump_pc;
        end
        TRAP_JUMP: state <= IDLE;
        MRET_JUMP: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed table-driven bench for trap_ctrl plus hand-written multi-cycle sequences.
module tb_trap_ctrl;

`ifdef TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic        ck_i = 1'b0;
  logic        rs_n_i;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_ins_i;
  logic        ecall_i;
  logic        ebreak_i;
  logic        illegal_ins_i;
  logic        ld_misalign_i;
  logic        st_misalign_i;
  logic        mret_i;
  logic [31:0] misalign_addr_i;
  logic        mstatus_ie_i;
  logic        mie_external_i;
  logic        mie_timer_i;
  logic        mie_sw_i;
  logic        mip_external_i;
  logic        mip_timer_i;
  logic        mip_software_i;
  logic [31:0] mtvec_i;
  logic [31:0] epc_i;
  logic        kill_o;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        ie_type_o;
  logic        set_cause_o;
  logic [3:0]  trap_cause_o;
  logic        set_epc_o;
  logic [31:0] epc_o;
  logic        set_mtval_o;
  logic [31:0] mtval_o;
  logic        mstatus_ie_clear_o;
  logic        mstatus_ie_set_o;

  trap_ctrl dut (
    .ck_i(ck_i), .rs_n_i(rs_n_i),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_ins_i(ex_ins_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i),
    .illegal_ins_i(illegal_ins_i),
    .ld_misalign_i(ld_misalign_i), .st_misalign_i(st_misalign_i),
    .mret_i(mret_i), .misalign_addr_i(misalign_addr_i),
    .mstatus_ie_i(mstatus_ie_i),
    .mie_external_i(mie_external_i), .mie_timer_i(mie_timer_i),
    .mie_sw_i(mie_sw_i),
    .mip_external_i(mip_external_i), .mip_timer_i(mip_timer_i),
    .mip_software_i(mip_software_i),
    .mtvec_i(mtvec_i), .epc_i(epc_i),
    .kill_o(kill_o), .stall_o(stall_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .ie_type_o(ie_type_o),
    .set_cause_o(set_cause_o), .trap_cause_o(trap_cause_o),
    .set_epc_o(set_epc_o), .epc_o(epc_o),
    .set_mtval_o(set_mtval_o), .mtval_o(mtval_o),
    .mstatus_ie_clear_o(mstatus_ie_clear_o),
    .mstatus_ie_set_o(mstatus_ie_set_o)
  );

  always #5 ck_i = ~ck_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ck_i);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid_i      = 1'b0;
    ex_pc_i         = 32'd0;
    ex_ins_i        = 32'd0;
    ecall_i         = 1'b0;
    ebreak_i        = 1'b0;
    illegal_ins_i   = 1'b0;
    ld_misalign_i   = 1'b0;
    st_misalign_i   = 1'b0;
    mret_i          = 1'b0;
    misalign_addr_i = 32'd0;
    mstatus_ie_i    = 1'b0;
    mie_external_i  = 1'b0;
    mie_timer_i     = 1'b0;
    mie_sw_i        = 1'b0;
    mip_external_i  = 1'b0;
    mip_timer_i     = 1'b0;
    mip_software_i  = 1'b0;
  endtask

  function automatic logic any_out();
    return |{kill_o, stall_o, flush_o, redirect_o, redirect_pc_o,
             ie_type_o, set_cause_o, trap_cause_o, set_epc_o, epc_o,
             set_mtval_o, mtval_o, mstatus_ie_clear_o,
             mstatus_ie_set_o};
  endfunction

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] addr;
    logic [31:0] mtvec;
    logic        ill;
    logic        ec;
    logic        eb;
    logic        ld;
    logic        st;
    logic        msie;
    logic [2:0]  mie;
    logic [2:0]  mip;
    logic [3:0]  cause;
    logic        ie;
    logic [31:0] mtval;
    logic [31:0] tgt;
  } vec_t;

  vec_t tv[12];

  initial begin
    tv[0]  = '{"ecall", 32'h100, 32'h73, 32'h0, 32'h200,
               0, 1, 0, 0, 0, 0, 3'b000, 3'b000,
               4'd11, 0, 32'h0, 32'h200};
    tv[1]  = '{"timer", 32'h40, 32'h13, 32'h0, 32'h201,
               0, 0, 0, 0, 0, 1, 3'b010, 3'b010,
               4'd7, 1, 32'h0, VEC ? 32'h21C : 32'h200};
    tv[2]  = '{"illegal", 32'h300, 32'hFFFFFFFF, 32'h0, 32'h200,
               1, 0, 0, 0, 0, 0, 3'b000, 3'b000,
               4'd2, 0, 32'hFFFFFFFF, 32'h200};
    tv[3]  = '{"ext_tmr_ecall", 32'h80, 32'h73, 32'h0, 32'h201,
               0, 1, 0, 0, 0, 1, 3'b111, 3'b110,
               4'd11, 1, 32'h0, VEC ? 32'h22C : 32'h200};
    tv[4]  = '{"ext_tmr_ecall_nomie", 32'h80, 32'h73, 32'h0, 32'h201,
               0, 1, 0, 0, 0, 0, 3'b111, 3'b110,
               4'd11, 0, 32'h0, 32'h200};
    tv[5]  = '{"sw_tmr", 32'h84, 32'h13, 32'h0, 32'h201,
               0, 0, 0, 0, 0, 1, 3'b111, 3'b011,
               4'd3, 1, 32'h0, VEC ? 32'h20C : 32'h200};
    tv[6]  = '{"tmr_masked_ecall", 32'h88, 32'h73, 32'h0, 32'h201,
               0, 1, 0, 0, 0, 1, 3'b101, 3'b010,
               4'd11, 0, 32'h0, 32'h200};
    tv[7]  = '{"ebreak_ld", 32'h44, 32'h100073, 32'h1003, 32'h203,
               0, 0, 1, 1, 0, 0, 3'b000, 3'b000,
               4'd3, 0, 32'h44, 32'h200};
    tv[8]  = '{"ld_st", 32'h48, 32'h2003, 32'h1003, 32'h200,
               0, 0, 0, 1, 1, 0, 3'b000, 3'b000,
               4'd4, 0, 32'h1003, 32'h200};
    tv[9]  = '{"st", 32'h4C, 32'h2023, 32'h2002, 32'hFFFFFFFC,
               0, 0, 0, 0, 1, 0, 3'b000, 3'b000,
               4'd6, 0, 32'h2002, 32'hFFFFFFFC};
    tv[10] = '{"ill_ec_eb", 32'h50, 32'hDEADBEEF, 32'h0, 32'h200,
               1, 1, 1, 0, 0, 0, 3'b000, 3'b000,
               4'd2, 0, 32'hDEADBEEF, 32'h200};
    tv[11] = '{"ext_wrap", 32'h54, 32'h13, 32'h0, 32'hFFFFFFF1,
               0, 0, 0, 0, 0, 1, 3'b100, 3'b100,
               4'd11, 1, 32'h0, VEC ? 32'h1C : 32'hFFFFFFF0};
  end

  initial begin
    idle_inputs();
    mtvec_i = 32'h200;
    epc_i   = 32'h0;
    rs_n_i  = 1'b0;
    ex_valid_i = 1'b1;
    ecall_i    = 1'b1;
    #1;
    chk("reset_outputs", {31'd0, any_out()}, 32'd0);
    step();
    chk("reset_hold", {31'd0, any_out()}, 32'd0);
    idle_inputs();
    #2 rs_n_i = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      ex_valid_i      = 1'b1;
      ex_pc_i         = tv[i].pc;
      ex_ins_i        = tv[i].ins;
      misalign_addr_i = tv[i].addr;
      mtvec_i         = tv[i].mtvec;
      illegal_ins_i   = tv[i].ill;
      ecall_i         = tv[i].ec;
      ebreak_i        = tv[i].eb;
      ld_misalign_i   = tv[i].ld;
      st_misalign_i   = tv[i].st;
      mstatus_ie_i    = tv[i].msie;
      mie_external_i  = tv[i].mie[2];
      mie_timer_i     = tv[i].mie[1];
      mie_sw_i        = tv[i].mie[0];
      mip_external_i  = tv[i].mip[2];
      mip_timer_i     = tv[i].mip[1];
      mip_software_i  = tv[i].mip[0];
      #1;
      chk({tv[i].nm, " kill"}, {31'd0, kill_o}, 32'd1);
      step();
      idle_inputs();
      #1;
      chk({tv[i].nm, " n1_pulses"},
          {26'd0, set_cause_o, set_epc_o, set_mtval_o,
           mstatus_ie_clear_o, stall_o, flush_o}, 32'h3F);
      chk({tv[i].nm, " n1_noredir"},
          {30'd0, redirect_o, mstatus_ie_set_o}, 32'd0);
      chk({tv[i].nm, " cause"}, {28'd0, trap_cause_o},
          {28'd0, tv[i].cause});
      chk({tv[i].nm, " ie_type"}, {31'd0, ie_type_o}, {31'd0, tv[i].ie});
      chk({tv[i].nm, " epc"}, epc_o, tv[i].pc);
      chk({tv[i].nm, " mtval"}, mtval_o, tv[i].mtval);
      step();
      chk({tv[i].nm, " n2_redir"},
          {29'd0, redirect_o, flush_o, stall_o}, 32'h6);
      chk({tv[i].nm, " n2_nopulse"},
          {29'd0, set_cause_o, mstatus_ie_clear_o, mstatus_ie_set_o},
          32'd0);
      chk({tv[i].nm, " target"}, redirect_pc_o, tv[i].tgt);
      step();
      chk({tv[i].nm, " n3_idle"},
          {29'd0, redirect_o, flush_o, set_cause_o}, 32'd0);
    end

    // ex_valid low: flags ignored
    idle_inputs();
    ecall_i = 1'b1;
    illegal_ins_i = 1'b1;
    #1;
    chk("novalid kill", {31'd0, kill_o}, 32'd0);
    step();
    chk("novalid set_cause", {31'd0, set_cause_o}, 32'd0);
    idle_inputs();

    // mret
    epc_i = 32'h104;
    ex_valid_i = 1'b1;
    mret_i = 1'b1;
    step();
    idle_inputs();
    #1;
    chk("mret pulses",
        {28'd0, mstatus_ie_set_o, redirect_o, flush_o, stall_o}, 32'hE);
    chk("mret no_trap", {30'd0, set_cause_o, mstatus_ie_clear_o}, 32'd0);
    chk("mret pc", redirect_pc_o, 32'h104);
    step();
    chk("mret idle",
        {29'd0, mstatus_ie_set_o, redirect_o, flush_o}, 32'd0);

    // events during the sequence are ignored
    mtvec_i = 32'h200;
    ex_valid_i = 1'b1;
    ex_pc_i = 32'h100;
    ecall_i = 1'b1;
    step();
    ecall_i = 1'b0;
    illegal_ins_i = 1'b1;
    ex_ins_i = 32'h1234;
    ex_pc_i = 32'h104;
    #1;
    chk("busy kill", {31'd0, kill_o}, 32'd0);
    step();
    chk("busy cause", {28'd0, trap_cause_o}, 32'd11);
    chk("busy mtval", mtval_o, 32'd0);
    chk("busy epc", epc_o, 32'h100);
    idle_inputs();
    step();
    chk("busy no_retrap", {31'd0, set_cause_o}, 32'd0);

    // level irq must not be re-taken once MIE clears
    ex_valid_i = 1'b1;
    mstatus_ie_i = 1'b1;
    mie_timer_i = 1'b1;
    mip_timer_i = 1'b1;
    step();
    chk("reentry clear", {31'd0, mstatus_ie_clear_o}, 32'd1);
    mstatus_ie_i = 1'b0;
    step();
    step();
    chk("reentry kill", {31'd0, kill_o}, 32'd0);
    step();
    chk("reentry set_cause", {31'd0, set_cause_o}, 32'd0);
    idle_inputs();

    // async reset in TRAP_CSR
    ex_valid_i = 1'b1;
    ecall_i = 1'b1;
    ex_pc_i = 32'h100;
    step();
    idle_inputs();
    chk("pre_reset set_cause", {31'd0, set_cause_o}, 32'd1);
    rs_n_i = 1'b0;
    #1;
    chk("async_reset outputs", {31'd0, any_out()}, 32'd0);
    step();
    rs_n_i = 1'b1;
    step();
    chk("post_reset redir1", {31'd0, redirect_o}, 32'd0);
    step();
    chk("post_reset redir2", {30'd0, redirect_o, set_cause_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
